// File: rtl/shiftreg_seq_pkg.sv
// Shared definitions for the shiftreg command sequencer: shift-register op
// encoding and the sequencer state encoding.
package shiftreg_seq_pkg;

    // Op encoding understood by shiftreg.op
    localparam logic [2:0] OP_SHL_SIN = 3'b000;  // shift left, sin into bit 0
    localparam logic [2:0] OP_SHR_SIN = 3'b001;  // shift right, sin into bit 7
    localparam logic [2:0] OP_SHR_0   = 3'b010;  // shift right, zero fill
    localparam logic [2:0] OP_SHL_0   = 3'b011;  // shift left, zero fill
    localparam logic [2:0] OP_JOHN_L  = 3'b100;  // Johnson left: ~bit7 into bit 0
    localparam logic [2:0] OP_JOHN_R  = 3'b101;  // Johnson right: ~bit0 into bit 7
    localparam logic [2:0] OP_LOAD    = 3'b110;  // parallel load from datain
    localparam logic [2:0] OP_ROR2    = 3'b111;  // rotate right by two

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

endpackage

// File: rtl/shiftreg.sv
// 8-bit multi-mode shift register driven by shiftreg_seq. It has no idle op
// and no reset: holding a value means reloading it through OP_LOAD.
module shiftreg
    import shiftreg_seq_pkg::*;
(
    input  logic       clk,
    input  logic [2:0] op,
    input  logic [7:0] datain,
    input  logic       sin,
    output logic [7:0] out
);

    // Apply the selected op on every rising edge
    always_ff @(posedge clk) begin
        case (op)
            OP_SHL_SIN: out <= {out[6:0], sin};
            OP_SHR_SIN: out <= {sin, out[7:1]};
            OP_SHR_0:   out <= {1'b0, out[7:1]};
            OP_SHL_0:   out <= {out[6:0], 1'b0};
            OP_JOHN_L:  out <= {out[6:0], ~out[7]};
            OP_JOHN_R:  out <= {~out[0], out[7:1]};
            OP_LOAD:    out <= datain;
            default:    out <= {out[1:0], out[7:2]};
        endcase
    end

endmodule

// File: rtl/shiftreg_seq.sv
// Command sequencer for one shiftreg: optional preload, then a repeated
// shift op, then a one-cycle done pulse carrying the final register value.
// All sr_* and status outputs decode from registered state only.
module shiftreg_seq
    import shiftreg_seq_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_load,
    input  logic [7:0]       cmd_data,
    input  logic [2:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             cmd_sin,
    output logic             busy,
    output logic             done,
    output logic [7:0]       result,
    output logic [2:0]       sr_op,
    output logic [7:0]       sr_datain,
    output logic             sr_sin,
    input  logic [7:0]       sr_out
);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_count;
    logic [2:0]       r_op;
    logic [7:0]       r_data;
    logic             r_sin;
    logic             w_accept;

    // The load flag is consumed on the accept edge to pick LOAD vs SHIFT/DONE,
    // so it never needs to be read back from a register afterwards.
    assign w_accept = cmd_valid && (r_state == ST_IDLE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Capture the command fields on accept; inputs are free to change afterwards
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_op    <= '0;
            r_data  <= '0;
            r_sin   <= 1'b0;
        end else if (w_accept) begin
            r_count <= cmd_count;
            r_op    <= cmd_op;
            r_data  <= cmd_data;
            r_sin   <= cmd_sin;
        end
    end

    // Remaining-shift down-counter, armed when SHIFT is about to be entered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE:  if (w_accept && !cmd_load) r_cnt <= cmd_count;
                ST_LOAD:  r_cnt <= r_count;
                ST_SHIFT: r_cnt <= r_cnt - CNT_W'(1);
                default:  r_cnt <= r_cnt;
            endcase
        end
    end

    // Next-state and output decode; every non-active cycle drives the hold reload
    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        sr_op     = OP_LOAD;
        sr_datain = sr_out;
        sr_sin    = 1'b0;
        result    = sr_out;
        case (r_state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (w_accept) begin
                    if (cmd_load)              w_next = ST_LOAD;
                    else if (cmd_count != '0)  w_next = ST_SHIFT;
                    else                       w_next = ST_DONE;
                end
            end
            ST_LOAD: begin
                busy      = 1'b1;
                sr_datain = r_data;
                w_next    = (r_count != '0) ? ST_SHIFT : ST_DONE;
            end
            ST_SHIFT: begin
                busy      = 1'b1;
                sr_op     = r_op;
                sr_datain = r_data;
                sr_sin    = r_sin;
                w_next    = (r_cnt == CNT_W'(1)) ? ST_DONE : ST_SHIFT;
            end
            default: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: doc/shiftreg_seq.md
Name: shiftreg_seq

Overview:
- Command sequencer for the team's 8-bit multi-mode shift register (module shiftreg).
- Accepts one command: optional parallel preload, an operation code and a repeat count.
- Drives the register's op/datain/sin for the required number of cycles, then reports the result with a one-cycle done pulse.
- Sits between a control FSM or CPU-side register block and one shiftreg instance.

Parameters:
- CNT_W, 4, width of the repeat count; maximum shifts per command = 2^CNT_W - 1.

Ports:
- clk  in  1  system clock; everything is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; a command is accepted on the edge where cmd_valid && cmd_ready.
- cmd_load  in  1  1 = preload cmd_data before shifting.
- cmd_data  in  8  preload value.
- cmd_op  in  3  shift op applied each SHIFT cycle; same encoding as shiftreg.op.
- cmd_count  in  CNT_W  number of SHIFT cycles.
- cmd_sin  in  1  serial-in bit used during SHIFT.
- busy  out  1  high in LOAD, SHIFT and DONE.
- done  out  1  one-cycle pulse in DONE.
- result  out  8  equals sr_out; defined only while done=1.
- sr_op  out  3  to shiftreg.op.
- sr_datain  out  8  to shiftreg.datain.
- sr_sin  out  1  to shiftreg.sin.
- sr_out  in  8  from shiftreg.out.

Behaviour:
- Hold rule: shiftreg has no idle op, so every non-active cycle drives sr_op=3'b110 with sr_datain=sr_out. This reloads the register with its own value.
- Command capture: on accept, latch op, count, data, sin and load into internal registers. Inputs are don't-care after the accept edge.
- States: IDLE, LOAD, SHIFT, DONE (2-bit encoding). Down-counter cnt is CNT_W bits.
- IDLE:
  - cmd_ready=1; hold is driven.
  - On accept: if load=1, go to LOAD.
  - Otherwise, if count!=0, go to SHIFT with cnt=count.
  - Otherwise go to DONE.
- LOAD (exactly 1 cycle):
  - Drives sr_op=3'b110, sr_datain=latched data.
  - Next state is SHIFT with cnt=count, or DONE if count==0.
- SHIFT:
  - Drives sr_op=latched op and sr_sin=latched sin.
  - sr_datain=latched data, which matters only when op=3'b110.
  - cnt decrements each cycle; when cnt==1 the next state is DONE. Exactly count shift edges occur.
- DONE (exactly 1 cycle):
  - Hold is driven; done=1; result=sr_out, which is final because the last shift edge has already happened.
  - Next state is IDLE.
- Latency from the accept edge to done high: load + count + 1 cycles. Minimum is 1 cycle (load=0, count=0).
- cmd_valid while busy is ignored; cmd_ready=0 is back-pressure, and no command is queued.
- Back-to-back commands: a new command can be accepted in the cycle after DONE (IDLE lasts at least 1 cycle).
- sr_sin in IDLE, LOAD and DONE: 0.
- Reset, including mid-operation:
  - State=IDLE, cnt=0, latched fields=0, done=0, busy=0, cmd_ready=1.
  - Outputs revert to hold immediately (combinational on state).
  - Shift register contents are not cleared; whatever was shifted before reset remains.
- Outputs cmd_ready, busy, done, sr_op, sr_datain, sr_sin and result are decoded combinationally from the state register and latched fields. There is no combinational path from cmd_* to sr_*.

Decomposition:
- Shared package holds:
  - the op encoding constants OP_SHL_SIN=000, OP_SHR_SIN=001, OP_SHR_0=010, OP_SHL_0=011, OP_JOHN_L=100, OP_JOHN_R=101, OP_LOAD=110, OP_ROR2=111;
  - the state encoding.
- No sub-module inside shiftreg_seq.
- The test bench instantiates shiftreg_seq plus one shiftreg and wires sr_* together.

Test Plan:
- Preload and shift left with serial in: load=1, data=0xA5, op=000, sin=1, count=3 -> shift values 0x4B, 0x97, 0x2F; done in the 5th cycle after accept with result=0x2F.
- Rotate identity: load=1, data=0x81, op=111, count=4 -> result=0x81.
- Johnson fill: first a load-only command (load=1, data=0x00, count=0) -> result=0x00 one cycle after LOAD. Then load=0, op=100, count=8 -> intermediate values 0x01 through 0x7F, result=0xFF. Register stays 0xFF for 5 idle cycles (hold check).
- Count saturation: load=1, data=0xFF, op=010, count=15 -> result=0x00; busy high for 17 cycles; cmd_valid asserted throughout is not accepted until cmd_ready returns.
- Reset mid-shift: load=1, data=0xF0, op=011, count=10; assert rst after the 2nd shift edge -> busy=0 and cmd_ready=1 immediately, no done pulse, sr_out stays 0xC0 under hold.
- Minimum latency: load=0, count=0 -> done exactly 1 cycle after accept, result=current sr_out; accept a second command in the cycle after done.
